wb_arbiter: RTL
===============

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter: STARVE_LIMIT, default 4, cycles a buffered long-latency result may wait before the pipeline is stalled; legal range 1..15.
REQ-002 Ports:
- clk  in  1  sole clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- pipe_valid  in  1  in-order pipeline has a writeback this cycle.
- pipe_rd  in  5  pipeline destination register.
- pipe_mem_to_reg  in  1  1: write pipe_mem_data; 0: write pipe_alu_result.
- pipe_alu_result  in  32  ALU result.
- pipe_mem_data  in  32  load data.
- pipe_stall  out  1  pipeline must hold its writeback stage this cycle.
- mu_valid  in  1  long-latency unit (mul/div) offers a result.
- mu_ready  out  1  arbiter accepts the mu result this cycle.
- mu_rd  in  5  mu destination register.
- mu_data  in  32  mu result.
- rf_we  out  1  register-file write enable (registered).
- rf_waddr  out  5  register-file write address (registered).
- rf_wdata  out  32  register-file write data (registered).
- mu_pending  out  1  one or more mu results are buffered and not yet written.

Function
REQ-003 The block SHALL arbitrate the single register-file write port between the pipeline and the mu path.
REQ-004 The mu path SHALL use a 2-entry FIFO (rd, data); a transfer occurs when mu_valid=1 and mu_ready=1.
REQ-005 mu_ready SHALL be 1 iff FIFO count < 2, independent of mu_valid.
REQ-006 Every accepted mu result SHALL enter the FIFO, with no bypass; the earliest possible write is the cycle after acceptance.
REQ-007 FSM states: NORMAL and FORCE_DRAIN; pipe_stall SHALL be 1 iff state = FORCE_DRAIN.
REQ-008 In NORMAL, the port owner SHALL be the pipeline if pipe_valid=1, else the FIFO head if count > 0, else none.
REQ-009 In FORCE_DRAIN, the FIFO head SHALL own the port regardless of pipe_valid; pipeline data SHALL be ignored that cycle.
REQ-010 A 4-bit starve counter SHALL increment in each cycle with count > 0 and no FIFO drain.
REQ-011 The starve counter SHALL clear on any drain or when count = 0.
REQ-012 NORMAL SHALL go to FORCE_DRAIN at the edge where the starve counter's next value equals STARVE_LIMIT.
REQ-013 FORCE_DRAIN SHALL always return to NORMAL after exactly one cycle.
REQ-014 The selected write SHALL appear on rf_we/rf_waddr/rf_wdata at the next rising edge (1-cycle latency).
REQ-015 When no owner exists, rf_we SHALL be 0; rf_waddr and rf_wdata SHALL hold their previous values.
REQ-016 Pipeline data SHALL be pipe_mem_data when pipe_mem_to_reg=1, else pipe_alu_result.
REQ-017 A write with rd = 0 SHALL produce rf_we=0 but still consume its source; an x0 FIFO head still pops.
REQ-018 If the FIFO drains and accepts in the same cycle, count SHALL be unchanged and order SHALL be preserved.
REQ-019 The FIFO SHALL never overflow or underflow; accept at count=2 and pop at count=0 are impossible by construction.
REQ-020 mu_pending SHALL equal (count > 0).
REQ-021 No combinational path SHALL exist from mu_valid to mu_ready or from any input to pipe_stall.

Reset
REQ-022 On rst_n=0, immediately and asynchronously: state=NORMAL, count=0, starve counter=0, rf_we=0, rf_waddr=0, rf_wdata=0, pipe_stall=0, mu_pending=0, mu_ready=1.
REQ-023 Reset asserted mid-operation SHALL discard buffered mu results, with no write issued for them.
REQ-024 After deassertion, the first write SHALL occur no earlier than the edge following the first valid request.

Verification
REQ-025 Pipe only: pipe_valid=1, rd=5, mem_to_reg=0, alu=0x11 -> next cycle rf_we=1, waddr=5, wdata=0x11; repeat with mem_to_reg=1, mem=0x22 -> wdata=0x22.
REQ-026 Idle pipe: mu rd=7, data=0xABCD accepted at cycle T -> rf_we=1, waddr=7 after edge T+1; mu_pending 1 then 0.
REQ-027 Starvation (LIMIT=4): pipe_valid held 1 and one mu result buffered -> pipe_stall=1 for exactly one cycle, 4 cycles after acceptance.
- Then mu write issues and the pipe resumes.
REQ-028 Backpressure: pipe_valid held 1 and three back-to-back mu offers -> first two accepted, mu_ready=0 on the third until a forced drain.
- Writes occur in FIFO order.
REQ-029 x0 handling: pipe rd=0 -> rf_we=0; mu rd=0 -> FIFO pops, rf_we=0, mu_pending clears.
REQ-030 Reset with 2 entries buffered -> all outputs at reset values immediately; no mu write appears after release.

Source files
------------

// File: rtl/wb_arbiter.sv
// -----------------------------------------------------------------------------
// wb_arbiter
//   Shares the single register-file write port between the in-order pipeline
//   writeback and a long-latency unit (mul/div). Long-latency results are
//   buffered in a 2-entry FIFO. The pipeline normally wins the port. A starve
//   counter forces one drain cycle when a buffered result has waited
//   STARVE_LIMIT cycles.
//
// Handshake (mu path): a result transfers on any rising edge where
//   mu_valid=1 and mu_ready=1. mu_ready depends only on FIFO occupancy, never
//   on mu_valid. The producer must hold rd/data stable while mu_valid=1 and
//   mu_ready=0.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   pipe_*            pipeline writeback request (valid, rd, data select)
//   pipe_stall        pipeline must hold its writeback stage this cycle
//   mu_valid/ready    long-latency result handshake
//   mu_rd, mu_data    long-latency result payload
//   rf_we/waddr/wdata registered register-file write port
//   mu_pending        at least one buffered mu result not yet written
// -----------------------------------------------------------------------------
module wb_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pipe_valid,
  input  logic [4:0]  pipe_rd,
  input  logic        pipe_mem_to_reg,
  input  logic [31:0] pipe_alu_result,
  input  logic [31:0] pipe_mem_data,
  output logic        pipe_stall,
  input  logic        mu_valid,
  output logic        mu_ready,
  input  logic [4:0]  mu_rd,
  input  logic [31:0] mu_data,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        mu_pending
);

  typedef enum logic {
    NORMAL      = 1'b0,
    FORCE_DRAIN = 1'b1
  } state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t      state_q, state_d;
  logic [1:0]  count_q, count_d;
  logic        head_q, head_d;
  logic [3:0]  starve_q, starve_d;
  logic [4:0]  fifo_rd_q   [2];
  logic [4:0]  fifo_rd_d   [2];
  logic [31:0] fifo_data_q [2];
  logic [31:0] fifo_data_d [2];
  logic        rf_we_q, rf_we_d;
  logic [4:0]  rf_waddr_q, rf_waddr_d;
  logic [31:0] rf_wdata_q, rf_wdata_d;

  logic        mu_accept;
  logic        own_pipe;
  logic        own_fifo;
  logic        wr_idx;

  // All outputs below are functions of registered state only.
  assign mu_ready   = (count_q != 2'd2);
  assign pipe_stall = (state_q == FORCE_DRAIN);
  assign mu_pending = (count_q != 2'd0);
  assign rf_we      = rf_we_q;
  assign rf_waddr   = rf_waddr_q;
  assign rf_wdata   = rf_wdata_q;

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    head_d      = head_q;
    starve_d    = starve_q;
    fifo_rd_d   = fifo_rd_q;
    fifo_data_d = fifo_data_q;
    rf_we_d     = 1'b0;
    rf_waddr_d  = rf_waddr_q;
    rf_wdata_d  = rf_wdata_q;
    own_pipe    = 1'b0;
    own_fifo    = 1'b0;

    mu_accept = mu_valid && (count_q != 2'd2);

    // Port ownership: the forced drain cycle ignores the pipeline entirely.
    if (state_q == FORCE_DRAIN) begin
      own_fifo = (count_q != 2'd0);
    end else if (pipe_valid) begin
      own_pipe = 1'b1;
    end else begin
      own_fifo = (count_q != 2'd0);
    end

    // x0 writes consume their source but never assert the write enable;
    // address/data only move on a real write.
    if (own_pipe && (pipe_rd != 5'd0)) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = pipe_rd;
      rf_wdata_d = pipe_mem_to_reg ? pipe_mem_data : pipe_alu_result;
    end else if (own_fifo && (fifo_rd_q[head_q] != 5'd0)) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = fifo_rd_q[head_q];
      rf_wdata_d = fifo_data_q[head_q];
    end

    // Tail slot is head+count; with count<2 when accepting this is always
    // the slot not holding the live head, so a simultaneous pop keeps order.
    wr_idx = head_q ^ count_q[0];
    if (mu_accept) begin
      fifo_rd_d[wr_idx]   = mu_rd;
      fifo_data_d[wr_idx] = mu_data;
    end
    if (own_fifo) begin
      head_d = ~head_q;
    end
    count_d = count_q + 2'(mu_accept) - 2'(own_fifo);

    if ((count_q == 2'd0) || own_fifo) begin
      starve_d = 4'd0;
    end else begin
      starve_d = starve_q + 4'd1;
    end

    case (state_q)
      NORMAL:      if (starve_d == LIMIT) state_d = FORCE_DRAIN;
      FORCE_DRAIN: state_d = NORMAL;
      default:     state_d = NORMAL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= NORMAL;
      count_q     <= 2'd0;
      head_q      <= 1'b0;
      starve_q    <= 4'd0;
      fifo_rd_q   <= '{default: 5'd0};
      fifo_data_q <= '{default: 32'd0};
      rf_we_q     <= 1'b0;
      rf_waddr_q  <= 5'd0;
      rf_wdata_q  <= 32'd0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      head_q      <= head_d;
      starve_q    <= starve_d;
      fifo_rd_q   <= fifo_rd_d;
      fifo_data_q <= fifo_data_d;
      rf_we_q     <= rf_we_d;
      rf_waddr_q  <= rf_waddr_d;
      rf_wdata_q  <= rf_wdata_d;
    end
  end

endmodule
